// File: rtl/seg_scan_capture_if.sv
// Scanned 7-segment bus and decoded frame outputs.
// master: display/bench side; slave: capture block.
interface seg_scan_capture_if;
  logic [11:0] SEG_IN;
  logic [15:0] VAL;
  logic [3:0]  DP;
  logic        VALID;
  logic        GLYPH_ERR;
  logic        ANODE_ERR;
  logic        STALE;

  modport master (
    output SEG_IN,
    input  VAL, DP, VALID,
    input  GLYPH_ERR, ANODE_ERR, STALE
  );

  modport slave (
    input  SEG_IN,
    output VAL, DP, VALID,
    output GLYPH_ERR, ANODE_ERR, STALE
  );
endinterface

// File: rtl/seg_scan_capture.sv
// Samples a scanned 4-digit 7-segment bus and decodes the shown word.
// SEG_SCAN_CAPTURE_HEX_EN: also accept A..F glyphs as legal.
module seg_scan_capture #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic CLK,
  input  logic RESET,
  seg_scan_capture_if.slave bus
);

  localparam int SW = $clog2(TIMEOUT + 1);

  typedef enum logic {COLLECT, PUBLISH} state_e;

  state_e state_q, state_d;

  logic [11:0] sync1_q, s_q, prev_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        chg, settled;

  logic        cap, an_bad;
  logic [1:0]  cap_idx;
  logic [4:0]  dec;

  logic [15:0] buf_q, buf_d;
  logic [3:0]  dpb_q, dpb_d;
  logic [3:0]  seen_q, seen_d;
  logic        ferr_q, ferr_d;

  logic [15:0] val_q;
  logic [3:0]  dp_q;
  logic        gerr_q, aerr_q;
  logic [SW-1:0] stale_q, stale_d;

  logic        load, valid, stale;

  function automatic logic [4:0] glyph(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h40: r = 5'h00;
      7'h79: r = 5'h01;
      7'h24: r = 5'h02;
      7'h30: r = 5'h03;
      7'h19: r = 5'h04;
      7'h12: r = 5'h05;
      7'h02: r = 5'h06;
      7'h78: r = 5'h07;
      7'h00: r = 5'h08;
      7'h10: r = 5'h09;
`ifdef SEG_SCAN_CAPTURE_HEX_EN
      7'h08: r = 5'h0A;
      7'h03: r = 5'h0B;
      7'h46: r = 5'h0C;
      7'h21: r = 5'h0D;
      7'h06: r = 5'h0E;
      7'h0E: r = 5'h0F;
`endif
      default: r = 5'h1F;
    endcase
    return r;
  endfunction

  assign chg     = (s_q != prev_q);
  assign settled = !chg && (cnt_q == 8'(SETTLE - 1));
  assign dec     = glyph(s_q[6:0]);

  always_comb begin
    cnt_d = cnt_q;
    if (chg)
      cnt_d = '0;
    else if (cnt_q != 8'hFF)
      cnt_d = cnt_q + 8'd1;
  end

  always_comb begin
    cap     = 1'b0;
    cap_idx = 2'd0;
    an_bad  = 1'b0;
    if (settled) begin
      unique case (s_q[11:8])
        4'b1111: ;
        4'b1110: begin cap = 1'b1; cap_idx = 2'd0; end
        4'b1101: begin cap = 1'b1; cap_idx = 2'd1; end
        4'b1011: begin cap = 1'b1; cap_idx = 2'd2; end
        4'b0111: begin cap = 1'b1; cap_idx = 2'd3; end
        default: an_bad = 1'b1;
      endcase
    end
  end

  // frame state: register / next-state / outputs
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (seen_q == 4'hF) state_d = PUBLISH;
      PUBLISH: state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    load  = (state_q == COLLECT) && (seen_q == 4'hF);
    valid = (state_q == PUBLISH);
    stale = !valid && (stale_q == SW'(TIMEOUT));
  end

  // the frame buffer restarts on the publish edge, so any capture
  // landing there already belongs to the next frame
  always_comb begin
    buf_d  = buf_q;
    dpb_d  = dpb_q;
    seen_d = load ? 4'h0 : seen_q;
    ferr_d = load ? 1'b0 : ferr_q;
    if (cap) begin
      buf_d[{cap_idx, 2'b00} +: 4] = dec[3:0];
      dpb_d[cap_idx]  = ~s_q[7];
      seen_d[cap_idx] = 1'b1;
      if (dec[4]) ferr_d = 1'b1;
    end
  end

  always_comb begin
    stale_d = stale_q;
    if (valid)
      stale_d = '0;
    else if (stale_q != SW'(TIMEOUT))
      stale_d = stale_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= 12'hFFF;
      s_q     <= 12'hFFF;
      prev_q  <= 12'hFFF;
      cnt_q   <= '0;
      buf_q   <= '0;
      dpb_q   <= '0;
      seen_q  <= '0;
      ferr_q  <= 1'b0;
      val_q   <= '0;
      dp_q    <= '0;
      gerr_q  <= 1'b0;
      aerr_q  <= 1'b0;
      stale_q <= '0;
    end else begin
      sync1_q <= bus.SEG_IN;
      s_q     <= sync1_q;
      prev_q  <= s_q;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      dpb_q   <= dpb_d;
      seen_q  <= seen_d;
      ferr_q  <= ferr_d;
      aerr_q  <= an_bad;
      stale_q <= stale_d;
      if (load) begin
        val_q  <= buf_q;
        dp_q   <= dpb_q;
        gerr_q <= ferr_q;
      end
    end
  end

  assign bus.VAL       = val_q;
  assign bus.DP        = dp_q;
  assign bus.VALID     = valid;
  assign bus.GLYPH_ERR = gerr_q;
  assign bus.ANODE_ERR = aerr_q;
  assign bus.STALE     = stale;

endmodule
